uart_tx_fifo: RTL and testbench

Byte-oriented UART transmitter with a small input FIFO, clocked from the user-project clock and driving a Caravel `mprj_io` pad as serial TX. It accepts bytes over a val/rdy handshake, buffers them, and emits 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) at a fixed bit period. It is the transmit end of the link whose receive end is the testbench UART monitor, and it lets on-chip logic report results serially.

---
 rtl/uart_tx_fifo.sv | 100 ++++++++++
 tb/tb_uart_tx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a val/rdy circular-buffer FIFO (clk, resetb, in_val/in_rdy/in_msg in, tx/busy/count out)
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic                          in_val,
  output logic                          in_rdy,
  input  logic [7:0]                    in_msg,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push, pop, last;
  assign in_rdy = count_q != CW'(FIFO_DEPTH);
  assign push   = in_val && in_rdy;
  assign last   = baud_q == BAUD_LAST;
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    baud_d  = last ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: if (last) begin
        tx_d    = shift_q[0];
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (last) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        tx_d    = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (last) begin
        pop     = count_q != '0;
        shift_d = pop ? mem_q[rd_q] : shift_q;
        tx_d    = !pop;
        state_d = pop ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_msg;
  end
  assign tx    = tx_q;
  assign busy  = (state_q != IDLE) || (count_q != '0);
  assign count = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench, stimulus queues expected bytes and a UART monitor decodes tx and compares
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       in_val = 1'b0;
  logic       in_rdy;
  logic [7:0] in_msg = '0;
  logic       tx;
  logic       busy;
  logic [2:0] count;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] sb[$];
  int         fs[$];
  int         nframes = 0;
  int         last_start = 0;
  bit         m_active = 0;
  int         m_cnt = 0;
  bit         m_glitch = 0;
  logic       m_v = 1'b1;
  logic [7:0] m_byte = '0;
  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetb(resetb), .in_val(in_val), .in_rdy(in_rdy),
    .in_msg(in_msg), .tx(tx), .busy(busy), .count(count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!resetb) begin
      m_active = 0;
      m_cnt = 0;
    end else if (!m_active) begin
      if (tx === 1'b0) begin
        m_active = 1;
        m_cnt = 0;
        m_glitch = 0;
        m_v = 1'b0;
        last_start = cyc;
        fs.push_back(cyc);
        nframes++;
      end
    end else begin
      m_cnt++;
      if (m_cnt % 4 == 0) begin
        m_v = tx;
        if (m_cnt / 4 >= 1 && m_cnt / 4 <= 8) m_byte[(m_cnt / 4) - 1] = tx;
      end else if (tx !== m_v) m_glitch = 1;
      if (m_cnt == 39) begin
        m_active = 0;
        chk("stop_bit", {31'd0, m_v}, 1);
        chk("bit_width", {31'd0, m_glitch}, 0);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_frame: got 0x%0h expected no frame (cycle %0d)", m_byte, cyc);
        end else chk("frame_byte", {24'd0, m_byte}, {24'd0, sb.pop_front()});
      end
    end
  end
  task automatic push(input logic [7:0] b, output int n);
    int k = 0;
    @(negedge clk);
    in_val = 1'b1;
    in_msg = b;
    while (!in_rdy && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("push_ready", {31'd0, in_rdy}, 1);
    sb.push_back(b);
    @(posedge clk);
    #1;
    n = cyc;
    in_val = 1'b0;
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic drain();
    int k = 0;
    while (!(sb.size() == 0 && !busy && !m_active) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_done", {31'd0, k < 3000}, 1);
  endtask
  initial begin
    int n, n0, s, bad, acc, k, nf;
    bit first_low, prev_rdy, r;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_in_rdy", {31'd0, in_rdy}, 1);
    chk("rst_count", {29'd0, count}, 0);
    resetb = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("idle_tx_high", bad, 0);
    // single byte 0xA5
    fs.delete();
    push(8'hA5, n);
    wait_cyc(n + 40);
    chk("single_busy_before_idle", {31'd0, busy}, 1);
    wait_cyc(n + 41);
    chk("single_busy_after_idle", {31'd0, busy}, 0);
    chk("single_start_cycle", fs.size() > 0 ? fs[0] : -1, n + 1);
    drain();
    // back-to-back
    fs.delete();
    push(8'h00, n0);
    chk("b2b_count0", {29'd0, count}, 1);
    push(8'hFF, n);
    chk("b2b_count1", {29'd0, count}, 1);
    push(8'h55, n);
    drain();
    chk("b2b_frames", fs.size(), 3);
    if (fs.size() == 3) begin
      chk("b2b_first_start", fs[0], n0 + 1);
      chk("b2b_gap01", fs[1] - fs[0], 40);
      chk("b2b_gap12", fs[2] - fs[1], 40);
    end
    chk("b2b_count_end", {29'd0, count}, 0);
    // full / backpressure
    acc = 0; k = 0; first_low = 0; prev_rdy = 1;
    while (acc < 8 && k < 2000) begin
      @(negedge clk);
      k++;
      in_val = 1'b1;
      in_msg = 8'(8'h10 + acc);
      r = in_rdy;
      if (!r && prev_rdy && !first_low) begin
        first_low = 1;
        chk("bp_accepted_at_full", acc, 5);
        chk("bp_count_full", {29'd0, count}, 4);
      end
      if (r && !prev_rdy) chk("bp_rise_count", {29'd0, count}, 3);
      prev_rdy = r;
      if (r) begin
        sb.push_back(in_msg);
        acc++;
      end
    end
    @(posedge clk);
    #1;
    in_val = 1'b0;
    chk("bp_all_accepted", acc, 8);
    chk("bp_saw_full", {31'd0, first_low}, 1);
    drain();
    // reset mid-frame
    nf = nframes;
    push(8'h3C, n);
    push(8'h01, n);
    push(8'h02, n);
    k = 0;
    while (nframes == nf && k < 100) begin
      @(negedge clk);
      k++;
    end
    s = last_start;
    wait_cyc(s + 17);
    chk("mid_count_before", {29'd0, count}, 2);
    chk("mid_bit3", {31'd0, tx}, 1);
    #1 resetb = 1'b0;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 1);
    chk("mid_rst_count", {29'd0, count}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    nf = nframes;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("mid_quiet_tx", bad, 0);
    chk("mid_quiet_frames", nframes - nf, 0);
    // simultaneous push/pop at last STOP cycle
    fs.delete();
    push(8'h41, n);
    push(8'h42, n);
    s = n;
    wait_cyc(s + 39);
    chk("sim_count_before", {29'd0, count}, 1);
    in_val = 1'b1;
    in_msg = 8'h99;
    sb.push_back(8'h99);
    @(posedge clk);
    #1;
    in_val = 1'b0;
    chk("sim_count_after", {29'd0, count}, 1);
    drain();
    chk("sim_frames", fs.size(), 3);
    if (fs.size() == 3) begin
      chk("sim_gap01", fs[1] - fs[0], 40);
      chk("sim_gap12", fs[2] - fs[1], 40);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end
endmodule
